left_l_shifter: RTL and testbench

LEFT_L_SHIFTER -- requirements
Module: left_l_shifter

---
 rtl/left_l_shifter_pkg.sv | 12 +
 rtl/left_shift_stage.sv | 23 ++
 rtl/left_l_shifter.sv | 56 +++++
 tb/tb_left_l_shifter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/left_l_shifter_pkg.sv
// Shared sizing for the logical left shifter and the stage-distance helper
// used to build its logarithmic barrel.
package left_l_shifter_pkg;

  localparam int unsigned XLEN    = 32'd32;
  localparam int unsigned SHAMT_W = 32'd5;

  function automatic int unsigned stage_dist(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/left_shift_stage.sv
// One barrel stage: shifts left by a fixed distance when enabled, otherwise
// passes the word through unchanged.
module left_shift_stage
  import left_l_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned SHIFT = 32'd1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      dout = din << SHIFT;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/left_l_shifter.sv
// Logical left shifter with RV32I SLL semantics: only the low SHAMT_W bits
// of B select the distance. S is combinational, S_q is its one-cycle copy.
module left_l_shifter
  import left_l_shifter_pkg::*;
#(
  parameter int unsigned XLEN    = left_l_shifter_pkg::XLEN,
  parameter int unsigned SHAMT_W = left_l_shifter_pkg::SHAMT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] S,
  output logic [XLEN-1:0] S_q
);

  logic [SHAMT_W-1:0]           shamt_s;
  logic                         unused_b_hi_s;
  logic [SHAMT_W:0][XLEN-1:0]   chain_s;
  logic [XLEN-1:0]              s_q_d;
  logic [XLEN-1:0]              s_q_q;

  // Upper bits of B are architecturally ignored.
  assign shamt_s       = B[SHAMT_W-1:0];
  assign unused_b_hi_s = ^B[XLEN-1:SHAMT_W];

  assign chain_s[0] = A;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    left_shift_stage #(
      .WIDTH (XLEN),
      .SHIFT (stage_dist(k))
    ) u_stage (
      .din  (chain_s[k]),
      .en   (shamt_s[k]),
      .dout (chain_s[k+1])
    );
  end

  assign S = chain_s[SHAMT_W];

  always_comb begin
    s_q_d = S;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q_q <= '0;
    end else begin
      s_q_q <= s_q_d;
    end
  end

  assign S_q = s_q_q;

endmodule

// File: tb/tb_left_l_shifter.sv
// Directed and random checks of the combinational shift result and its
// registered copy, including synchronous reset behaviour.
module tb_left_l_shifter;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] S;
  logic [31:0] S_q;

  int n_vec;
  int n_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  vec_t tbl [0:10];

  left_l_shifter dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .S   (S),
    .S_q (S_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rexp;

    n_vec = 0;
    n_err = 0;

    tbl[0]  = '{32'hFFFF_FFFF, 32'd4,          32'hFFFF_FFF0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'd31,         32'h8000_0000};
    tbl[2]  = '{32'h1234_5678, 32'h0000_0020,  32'h1234_5678};
    tbl[3]  = '{32'h1234_5678, 32'hFFFF_FFE1,  32'h2468_ACF0};
    tbl[4]  = '{32'h1234_5678, 32'd0,          32'h1234_5678};
    tbl[5]  = '{32'h1234_5678, 32'd33,         32'h2468_ACF0};
    tbl[6]  = '{32'hA5A5_A5A5, 32'd8,          32'hA5A5_A500};
    tbl[7]  = '{32'hA5A5_A5A5, 32'd16,         32'hA5A5_0000};
    tbl[8]  = '{32'h8000_0001, 32'd1,          32'h0000_0002};
    tbl[9]  = '{32'hDEAD_BEEF, 32'd3,          32'hF56D_F778};
    tbl[10] = '{32'h0F0F_0F0F, 32'd7,          32'h8787_8780};

    // Reset: S_q clears while S still follows A/B.
    rst = 1'b1;
    A   = 32'd5;
    B   = 32'd1;
    @(posedge clk);
    #1;
    check("reset_s_q", S_q, 32'h0000_0000);
    check("reset_s_comb", S, 32'h0000_000A);

    @(negedge clk);
    rst = 1'b0;
    A   = 32'd3;
    B   = 32'd2;
    @(posedge clk);
    #1;
    check("post_reset_s_q", S_q, 32'h0000_000C);

    // Walking one.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      A = 32'd1;
      B = i;
      #1;
      check("walk_one_s", S, 32'd1 << i);
    end

    // Directed table, combinational then registered.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      A = tbl[i].a;
      B = tbl[i].b;
      #1;
      check("table_s", S, tbl[i].s);
      @(posedge clk);
      #1;
      check("table_s_q", S_q, tbl[i].s);
    end

    // Reset on the same edge a new S appears, then resume.
    @(negedge clk);
    A   = 32'h0000_0010;
    B   = 32'd4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_override_s_q", S_q, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_resume_s_q", S_q, 32'h0000_0100);

    // Mid-operation reset clears, then tracking resumes.
    @(negedge clk);
    A = 32'h0000_00FF;
    B = 32'd8;
    @(posedge clk);
    #1;
    check("mid_load_s_q", S_q, 32'h0000_FF00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_s_q", S_q, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_resume_s_q", S_q, 32'h0000_FF00);

    // Random vectors against the shift-operator reference.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra   = $urandom;
      rb   = $urandom;
      rexp = ra << rb[4:0];
      A    = ra;
      B    = rb;
      #1;
      check("rand_s", S, rexp);
      @(posedge clk);
      #1;
      check("rand_s_q", S_q, rexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
